// File: rtl/fft_stage_ctrl_if.sv
// ---------------------------------------------------------------------------
// fft_stage_ctrl_if
// Handshake and control bundle between a radix-2 FFT stage sequencer and
// its surroundings (upstream source, downstream sink, coefficient
// generators, datapath clock enables).
//
//   in_valid / in_sof / in_ready : upstream beat handshake and frame start
//   out_ready                    : downstream acceptance
//   pipe_en                      : datapath register clock enable
//   coeff_addr / coeff_en        : twiddle index and advance strobe
//   out_valid / out_sof / out_eof: tags aligned with the stage outputs
//   frame_err / err_cnt          : framing violation pulse and counter
//   busy                         : frame in progress or pipeline occupied
//
// Modport "slave" is the sequencer; modport "master" is its environment.
// ---------------------------------------------------------------------------
interface fft_stage_ctrl_if #(
    parameter int ADDRW = 3,
    parameter int ERRW  = 8
);
    logic             in_valid;
    logic             in_sof;
    logic             in_ready;
    logic             out_ready;
    logic             pipe_en;
    logic [ADDRW-1:0] coeff_addr;
    logic             coeff_en;
    logic             out_valid;
    logic             out_sof;
    logic             out_eof;
    logic             frame_err;
    logic [ERRW-1:0]  err_cnt;
    logic             busy;

    modport master (
        output in_valid, in_sof, out_ready,
        input  in_ready, pipe_en, coeff_addr, coeff_en,
               out_valid, out_sof, out_eof, frame_err, err_cnt, busy
    );

    modport slave (
        input  in_valid, in_sof, out_ready,
        output in_ready, pipe_en, coeff_addr, coeff_en,
               out_valid, out_sof, out_eof, frame_err, err_cnt, busy
    );
endinterface

// File: rtl/fft_stage_ctrl.sv
// ---------------------------------------------------------------------------
// fft_stage_ctrl
// Frame sequencer for one radix-2 FFT stage (two butterfly lanes, NPAR
// complex samples per beat). Counts beats in each N-point frame, drives the
// twiddle address/enable, and carries valid/SOF/EOF tags through a LAT-deep
// shift pipeline so they line up with the datapath outputs. One global
// enable (pipe_en) stalls the datapath and the tag pipeline together.
//
// Ports:
//   clk  : stage clock
//   rst  : asynchronous, active-high reset
//   bus  : fft_stage_ctrl_if.slave (handshake, coefficient, tag, error and
//          status signals)
// ---------------------------------------------------------------------------
module fft_stage_ctrl #(
    parameter int N     = 32,
    parameter int NPAR  = 4,
    parameter int LAT   = 2,
    parameter int ADDRW = 3,
    parameter int ERRW  = 8
) (
    input  logic               clk,
    input  logic               rst,
    fft_stage_ctrl_if.slave    bus
);
    localparam int               C        = N / NPAR;
    localparam logic [ADDRW-1:0] CNT_LAST = ADDRW'(C - 1);
    localparam logic [ERRW-1:0]  ERR_MAX  = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [ADDRW-1:0] cnt;
    logic [LAT-1:0]   vld_p;   // bit i = tag stage i; bit LAT-1 drives the outputs
    logic [LAT-1:0]   sof_p;
    logic [LAT-1:0]   eof_p;
    logic             frame_err_q;
    logic [ERRW-1:0]  err_cnt_q;

    logic             pipe_en;
    logic             accept;
    logic             keep;
    logic             err_now;
    logic             is_eof;
    logic [ADDRW-1:0] beat_idx;

    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        return (v == ERR_MAX) ? v : v + ERRW'(1);
    endfunction

    // Stage p0 input: acceptance and beat classification
    assign pipe_en  = bus.out_ready | ~vld_p[LAT-1];
    assign accept   = bus.in_valid & pipe_en;
    // An SOF always restarts at beat 0, including an early SOF mid-frame.
    assign beat_idx = bus.in_sof ? '0 : cnt;
    // A non-SOF beat outside a frame is an orphan and is dropped.
    assign keep     = accept & (bus.in_sof | (state == RUN));
    assign err_now  = accept & (bus.in_sof ? (state == RUN) : (state == IDLE));
    assign is_eof   = keep & (beat_idx == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            vld_p       <= '0;
            sof_p       <= '0;
            eof_p       <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            frame_err_q <= err_now;
            if (err_now)
                err_cnt_q <= sat_inc(err_cnt_q);

            // Stages p0..p(LAT-1): tag shift, frozen together with the datapath
            if (pipe_en) begin
                vld_p <= (vld_p << 1) | LAT'(keep);
                sof_p <= (sof_p << 1) | LAT'(keep & bus.in_sof);
                eof_p <= (eof_p << 1) | LAT'(is_eof);
            end

            // keep implies pipe_en, so the frame counter never moves on a stall.
            if (keep) begin
                if (is_eof) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    state <= RUN;
                    cnt   <= beat_idx + ADDRW'(1);
                end
            end
        end
    end

    // Output stage: last tag stage and status
    assign bus.pipe_en    = pipe_en;
    assign bus.in_ready   = pipe_en;
    assign bus.coeff_addr = beat_idx;
    assign bus.coeff_en   = keep;
    assign bus.out_valid  = vld_p[LAT-1];
    assign bus.out_sof    = sof_p[LAT-1];
    assign bus.out_eof    = eof_p[LAT-1];
    assign bus.frame_err  = frame_err_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.busy       = (state == RUN) | (|vld_p);

endmodule
